nios_system_main_memory_master: RTL and testbench

- Avalon-MM master that drives the 8-bit × 4096 on-chip main memory slave port (address/chipselect/write/writedata/clken, readdata with fixed read latency).
- Moves byte blocks between Avalon-ST style byte streams and the memory:
  - FILL: stream sink to memory writes.
  - READ: memory reads to stream source, with backpressure.
- Commanded by a start pulse with base address and length. Sits between the Ethernet/TCP datapath and the main memory.

---
 rtl/nios_system_main_memory_master.sv | 255 +++++++++++++++++++++++++
 tb/tb_nios_system_main_memory_master.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_main_memory_master.sv
// -----------------------------------------------------------------------------
// nios_system_main_memory_master
//
// Avalon-MM master for the 8-bit main memory. Moves byte blocks between
// Avalon-ST style byte streams and the memory under a start/done handshake.
//   FILL (cmd_op = 0): snk_* byte stream -> memory writes, 1 byte/cycle.
//   READ (cmd_op = 1): memory reads -> src_* byte stream, with backpressure
//                      absorbed by a small first-word-fall-through buffer.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   cmd_start/op/base/len     command strobe, op, first address, byte count
//   busy, done                transfer in progress / one-cycle completion pulse
//   snk_data/valid/ready      FILL byte stream sink
//   src_data/valid/ready      READ byte stream source
//   mem_address/chipselect/write/writedata/clken/readdata
//                             memory slave port (fixed READ_LATENCY)
//   csum                      running 16-bit byte sum of the current transfer
//
// Optional feature: define MAIN_MEMORY_MASTER_CSUM_EN to build the checksum
// accumulator; otherwise csum is tied to zero.
// -----------------------------------------------------------------------------
module nios_system_main_memory_master #(
    parameter int ADDR_W       = 12,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_start,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,
    output logic              busy,
    output logic              done,
    input  logic [7:0]        snk_data,
    input  logic              snk_valid,
    output logic              snk_ready,
    output logic [7:0]        src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [7:0]        mem_writedata,
    output logic              mem_clken,
    input  logic [7:0]        mem_readdata,
    output logic [15:0]       csum
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);
    localparam logic [PW-1:0]     PTR_ONE  = PW'(1);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);

    logic [2:0]              state_q, state_d;
    logic [ADDR_W-1:0]       cur_q, cur_d;
    // FILL: bytes still to accept. READ: reads still to issue.
    logic [ADDR_W:0]         rem_q, rem_d;
    logic                    cs_q, cs_d;
    logic                    wr_q, wr_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [7:0]              wdata_q, wdata_d;

    // Read-return tracking and buffer
    logic [READ_LATENCY-1:0] sr_q, sr_d;
    logic [7:0]              fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]           wp_q, rp_q;
    logic [CW-1:0]           cnt_q;

    logic                    rd_live;
    logic                    push;
    logic                    pop;
    logic                    snk_fire;
    logic                    rd_issue;
    logic                    rd_phase;
    logic [OW-1:0]           inflight;
    logic [OW-1:0]           occupancy;

    assign mem_clken      = reset_n;
    assign mem_address    = addr_q;
    assign mem_chipselect = cs_q;
    assign mem_write      = wr_q;
    assign mem_writedata  = wdata_q;

    assign busy      = (state_q == ST_FILL) || (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign snk_ready = (state_q == ST_FILL) && (rem_q != '0);
    assign snk_fire  = snk_valid && snk_ready;
    assign rd_phase  = (state_q == ST_READ) || (state_q == ST_DRAIN);

    assign src_valid = (cnt_q != '0);
    assign src_data  = src_valid ? fifo_mem[rp_q] : '0;
    assign pop       = src_valid && src_ready && rd_phase;

    // A read strobe currently on the bus; its data returns READ_LATENCY
    // cycles later, when it reaches the end of the shift register.
    assign rd_live = cs_q && !wr_q;
    if (READ_LATENCY == 1) begin : g_sr1
        assign sr_d = rd_live;
    end else begin : g_srn
        assign sr_d = {sr_q[READ_LATENCY-2:0], rd_live};
    end
    assign push = sr_q[READ_LATENCY-1];

    // Credit covers buffered bytes plus every read still on its way, so an
    // issued read always has a buffer slot waiting for it.
    assign inflight  = OW'(rd_live) + OW'($countones(sr_q));
    assign occupancy = OW'(cnt_q) + inflight;
    assign rd_issue  = (state_q == ST_READ) && (rem_q != '0) && (occupancy < OW'(FIFO_DEPTH));

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rem_d   = rem_q;
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    cur_d = cmd_base;
                    rem_d = cmd_len;
                    if (cmd_len == '0) begin
                        state_d = ST_DONE;
                    end else if (cmd_op) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (snk_fire) begin
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = cur_q;
                    wdata_d = snk_data;
                    cur_d   = cur_q + ADDR_ONE;
                    rem_d   = rem_q - REM_ONE;
                end else if (rem_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_READ: begin
                if (rd_issue) begin
                    cs_d   = 1'b1;
                    addr_d = cur_q;
                    cur_d  = cur_q + ADDR_ONE;
                    rem_d  = rem_q - REM_ONE;
                end else if (rem_q == '0) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((inflight == '0) && (cnt_q == '0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sr_q    <= sr_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                wp_q <= wp_q + PTR_ONE;
            end
            if (pop) begin
                rp_q <= rp_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wp_q] <= mem_readdata;
        end
    end

`ifdef MAIN_MEMORY_MASTER_CSUM_EN
    logic [15:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if ((state_q == ST_IDLE) && cmd_start) begin
            csum_d = '0;
        end else if (snk_fire) begin
            csum_d = csum_q + {8'h00, snk_data};
        end else if (pop) begin
            csum_d = csum_q + {8'h00, src_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;
`else
    assign csum = '0;
`endif

endmodule

// File: tb/tb_nios_system_main_memory_master.sv
// -----------------------------------------------------------------------------
// Self-checking bench for nios_system_main_memory_master.
// Memory slave is modelled with a byte array and a READ_LATENCY pipeline;
// expected memory contents, write sequences and read streams come from a
// reference byte array indexed by (base + i) mod 4096.
// -----------------------------------------------------------------------------
module tb_nios_system_main_memory_master;
    parameter int RL = 1;
    localparam int AW    = 12;
    localparam int DEPTH = 4;
    localparam int MSIZE = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_start = 1'b0;
    logic          cmd_op = 1'b0;
    logic [AW-1:0] cmd_base = '0;
    logic [AW:0]   cmd_len = '0;
    logic          busy;
    logic          done;
    logic [7:0]    snk_data = '0;
    logic          snk_valid = 1'b0;
    logic          snk_ready;
    logic [7:0]    src_data;
    logic          src_valid;
    logic          src_ready = 1'b0;
    logic [AW-1:0] mem_address;
    logic          mem_chipselect;
    logic          mem_write;
    logic [7:0]    mem_writedata;
    logic          mem_clken;
    logic [7:0]    mem_readdata;
    logic [15:0]   csum;

    nios_system_main_memory_master #(
        .ADDR_W       (AW),
        .READ_LATENCY (RL),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_start      (cmd_start),
        .cmd_op         (cmd_op),
        .cmd_base       (cmd_base),
        .cmd_len        (cmd_len),
        .busy           (busy),
        .done           (done),
        .snk_data       (snk_data),
        .snk_valid      (snk_valid),
        .snk_ready      (snk_ready),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .csum           (csum)
    );

    always #5 clk = ~clk;

    // Memory slave model
    logic [7:0] mem     [MSIZE];
    logic [7:0] ref_mem [MSIZE];
    logic [7:0] rpipe   [RL];
    always @(posedge clk) begin
        if (mem_chipselect && mem_write) mem[mem_address] <= mem_writedata;
        rpipe[0] <= mem[mem_address];
        for (int k = 1; k < RL; k++) rpipe[k] <= rpipe[k-1];
    end
    assign mem_readdata = rpipe[RL-1];

    // Bus monitor, sampled mid-cycle
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] wr_a_q [$];
    logic [7:0]    wr_d_q [$];
    int            wr_c_q [$];
    int            acc_q  [$];
    logic [7:0]    rx_q   [$];
    logic [7:0]    fill_bytes [$];
    int rd_issued, rd_popped, ovf, done_cnt, done_cyc, cs_cnt, busy_cnt, done_busy;
    int start_cyc;
    int n_tests = 0;
    int n_fail  = 0;

    always @(negedge clk) begin
        if (mem_chipselect) cs_cnt++;
        if (mem_chipselect && mem_write) begin
            wr_a_q.push_back(mem_address);
            wr_d_q.push_back(mem_writedata);
            wr_c_q.push_back(cyc);
        end
        if (mem_chipselect && !mem_write) rd_issued++;
        if (rd_issued - rd_popped > DEPTH) ovf++;
        if (src_valid && src_ready) begin
            rx_q.push_back(src_data);
            rd_popped++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (done && busy) done_busy++;
    end

    function automatic logic [15:0] exp_csum(input int sum);
        logic [31:0] s;
        s = 32'(sum);
`ifdef MAIN_MEMORY_MASTER_CSUM_EN
        return s[15:0];
`else
        return 16'h0000 & s[15:0];
`endif
    endfunction

    task automatic clear_mon();
        wr_a_q.delete(); wr_d_q.delete(); wr_c_q.delete(); acc_q.delete(); rx_q.delete();
        rd_issued = 0; rd_popped = 0; ovf = 0; done_cnt = 0; done_cyc = -1;
        cs_cnt = 0; busy_cnt = 0; done_busy = 0;
    endtask

    task automatic start_cmd(input logic op, input logic [AW-1:0] base, input logic [AW:0] len);
        @(posedge clk); #1;
        cmd_op = op; cmd_base = base; cmd_len = len; cmd_start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        cmd_start = 1'b0;
    endtask

    task automatic feed_fill(input int len, input int prob, input bit inject);
        int idx = 0;
        int g = 0;
        while (idx < len && g < 20000) begin
            snk_valid = (int'($urandom_range(0, 99)) < prob);
            snk_data  = fill_bytes[idx];
            if (inject) begin
                cmd_start = (g == 2);
                cmd_op    = 1'b1;
                cmd_base  = '0;
                cmd_len   = 13'd1;
            end
            @(negedge clk);
            if (snk_valid && snk_ready) begin
                acc_q.push_back(cyc);
                idx++;
            end
            @(posedge clk); #1;
            g++;
        end
        snk_valid = 1'b0;
        cmd_start = 1'b0;
        n_tests++;
        if (idx != len) begin
            n_fail++;
            $display("FAIL fill_feed: accepted %0d bytes, want %0d", idx, len);
        end
    endtask

    task automatic wait_done(input string name);
        int g = 0;
        while (done_cnt == 0 && g < 20000) begin
            @(negedge clk);
            g++;
        end
        n_tests++;
        if (done_cnt == 0) begin
            n_fail++;
            $display("FAIL %s_done_timeout: done pulses %0d, want 1", name, done_cnt);
        end
    endtask

    task automatic post_checks(input string name, input int sum);
        n_tests++;
        if (done_cnt !== 1) begin
            n_fail++; $display("FAIL %s_done_count: got %0d, want 1", name, done_cnt);
        end
        n_tests++;
        if (busy !== 1'b0 || done_busy !== 0) begin
            n_fail++; $display("FAIL %s_busy_after: busy=%b done&busy cycles=%0d, want 0/0", name, busy, done_busy);
        end
        n_tests++;
        if (csum !== exp_csum(sum)) begin
            n_fail++; $display("FAIL %s_csum: got %h, want %h", name, csum, exp_csum(sum));
        end
    endtask

    task automatic do_fill(input logic [AW-1:0] base, input int len, input int prob, input bit inject);
        int sum = 0;
        logic [AW-1:0] ea;
        clear_mon();
        start_cmd(1'b0, base, len[AW:0]);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL fill_busy_rise: got %b, want 1", busy);
        end
        feed_fill(len, prob, inject);
        wait_done("fill");
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (wr_a_q.size() != len) begin
            n_fail++; $display("FAIL fill_write_count: got %0d, want %0d", wr_a_q.size(), len);
        end else begin
            for (int i = 0; i < len; i++) begin
                ea = AW'(int'(base) + i);
                n_tests++;
                if (wr_a_q[i] !== ea || wr_d_q[i] !== fill_bytes[i] || wr_c_q[i] != acc_q[i] + 1) begin
                    n_fail++;
                    $display("FAIL fill_write[%0d]: got addr=%h data=%h cyc=%0d, want addr=%h data=%h cyc=%0d",
                             i, wr_a_q[i], wr_d_q[i], wr_c_q[i], ea, fill_bytes[i], acc_q[i] + 1);
                end
            end
            n_tests++;
            if (done_cyc != wr_c_q[len-1] + 1) begin
                n_fail++; $display("FAIL fill_done_time: got cycle %0d, want %0d", done_cyc, wr_c_q[len-1] + 1);
            end
        end
        for (int i = 0; i < len; i++) begin
            ref_mem[AW'(int'(base) + i)] = fill_bytes[i];
            sum += int'(fill_bytes[i]);
        end
        post_checks("fill", sum);
    endtask

    task automatic do_read(input logic [AW-1:0] base, input int len, input int mode);
        int g = 0;
        int sum = 0;
        logic [7:0] eb;
        clear_mon();
        start_cmd(1'b1, base, len[AW:0]);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL read_busy_rise: got %b, want 1", busy);
        end
        while (done_cnt == 0 && g < 20000) begin
            case (mode)
                0:       src_ready = 1'b1;
                1:       src_ready = ((g % 4) == 0) || ((g % 4) == 3);
                default: src_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            @(posedge clk); #1;
            g++;
        end
        src_ready = 1'b0;
        n_tests++;
        if (done_cnt == 0) begin
            n_fail++; $display("FAIL read_done_timeout: no done after %0d cycles, want done", g);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (rx_q.size() != len || rd_issued != len) begin
            n_fail++; $display("FAIL read_count: got %0d bytes %0d reads, want %0d/%0d", rx_q.size(), rd_issued, len, len);
        end else begin
            for (int i = 0; i < len; i++) begin
                eb = ref_mem[AW'(int'(base) + i)];
                sum += int'(eb);
                n_tests++;
                if (rx_q[i] !== eb) begin
                    n_fail++; $display("FAIL read_byte[%0d]: got %h, want %h", i, rx_q[i], eb);
                end
            end
        end
        n_tests++;
        if (ovf !== 0) begin
            n_fail++; $display("FAIL read_credit: %0d cycles over buffer depth, want 0", ovf);
        end
        post_checks("read", sum);
    endtask

    task automatic rand_bytes(input int len);
        fill_bytes.delete();
        for (int i = 0; i < len; i++) fill_bytes.push_back(8'($urandom));
    endtask

    task automatic check_reset_outputs(input string name);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || snk_ready !== 1'b0 || src_valid !== 1'b0 ||
            mem_chipselect !== 1'b0 || mem_write !== 1'b0 || mem_address !== '0 ||
            mem_writedata !== '0 || src_data !== '0 || csum !== '0) begin
            n_fail++;
            $display("FAIL %s_outputs: busy=%b done=%b rdy=%b sv=%b cs=%b wr=%b a=%h wd=%h sd=%h cs16=%h, want all 0",
                     name, busy, done, snk_ready, src_valid, mem_chipselect, mem_write,
                     mem_address, mem_writedata, src_data, csum);
        end
        n_tests++;
        if (mem_clken !== 1'b0) begin
            n_fail++; $display("FAIL %s_clken: got %b, want 0", name, mem_clken);
        end
    endtask

    task automatic test_reset();
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (mem_clken !== 1'b1 || busy !== 1'b0 || src_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: clken=%b busy=%b src_valid=%b, want 1/0/0", mem_clken, busy, src_valid);
        end
    endtask

    task automatic test_fill_read_basic();
        fill_bytes.delete();
        fill_bytes.push_back(8'hA1); fill_bytes.push_back(8'hA2);
        fill_bytes.push_back(8'hA3); fill_bytes.push_back(8'hA4);
        do_fill(12'h010, 4, 100, 1'b0);
        n_tests++;
        if (wr_c_q.size() == 4 && wr_c_q[3] != wr_c_q[0] + 3) begin
            n_fail++; $display("FAIL fill_back_to_back: span %0d cycles, want 3", wr_c_q[3] - wr_c_q[0]);
        end
        do_read(12'h010, 4, 0);
    endtask

    task automatic test_wrap();
        rand_bytes(4);
        do_fill(12'hFFE, 4, 100, 1'b0);
        do_read(12'hFFE, 4, 1);
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] b;
        b = AW'($urandom_range(0, MSIZE - 1));
        rand_bytes(16);
        do_fill(b, 16, 60, 1'b0);
        do_read(b, 16, 1);
        do_read(b, 16, 2);
    endtask

    task automatic test_zero_len();
        clear_mon();
        start_cmd(1'b0, 12'h123, '0);
        // a start during the DONE cycle must be dropped
        cmd_start = 1'b1; cmd_op = 1'b0; cmd_len = 13'd5;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (done_cnt !== 1 || done_cyc != start_cyc + 1) begin
            n_fail++; $display("FAIL zero_len_done: pulses=%0d cycle=%0d, want 1 at %0d", done_cnt, done_cyc, start_cyc + 1);
        end
        n_tests++;
        if (cs_cnt !== 0 || busy_cnt !== 0) begin
            n_fail++; $display("FAIL zero_len_idle: chipselects=%0d busy cycles=%0d, want 0/0", cs_cnt, busy_cnt);
        end
        clear_mon();
        start_cmd(1'b1, 12'h456, '0);
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (done_cnt !== 1 || done_cyc != start_cyc + 1 || cs_cnt !== 0) begin
            n_fail++; $display("FAIL zero_len_read: pulses=%0d cycle=%0d cs=%0d, want 1 at %0d, 0", done_cnt, done_cyc, cs_cnt, start_cyc + 1);
        end
    endtask

    task automatic test_start_while_busy();
        rand_bytes(6);
        do_fill(12'h200, 6, 50, 1'b1);
        n_tests++;
        if (cs_cnt !== 6) begin
            n_fail++; $display("FAIL busy_start_ignored: chipselects %0d, want 6", cs_cnt);
        end
    endtask

    task automatic test_reset_mid_read();
        int g = 0;
        rand_bytes(8);
        do_fill(12'h300, 8, 100, 1'b0);
        clear_mon();
        start_cmd(1'b1, 12'h300, 13'd8);
        src_ready = 1'b1;
        while (rx_q.size() < 3 && g < 200) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk); #1;
        src_ready = 1'b0;
        n_tests++;
        if (rx_q.size() < 3) begin
            n_fail++; $display("FAIL mid_read_progress: got %0d bytes, want 3", rx_q.size());
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        do_read(12'h300, 8, 0);
        rand_bytes(5);
        do_fill(12'h305, 5, 80, 1'b0);
        do_read(12'h300, 10, 2);
    endtask

    task automatic test_random();
        logic [AW-1:0] b;
        int l;
        for (int it = 0; it < 4; it++) begin
            b = AW'($urandom_range(0, MSIZE - 1));
            l = int'($urandom_range(1, 40));
            rand_bytes(l);
            do_fill(b, l, int'($urandom_range(30, 100)), 1'b0);
            do_read(b, l, 2);
        end
    endtask

    task automatic test_csum();
        fill_bytes.delete();
        for (int i = 0; i < 258; i++) fill_bytes.push_back(8'hFF);
        do_fill(12'h700, 258, 100, 1'b0);
        n_tests++;
`ifdef MAIN_MEMORY_MASTER_CSUM_EN
        if (csum !== 16'h00FE) begin
            n_fail++; $display("FAIL csum_258xFF: got %h, want 00fe", csum);
        end
`else
        if (csum !== 16'h0000) begin
            n_fail++; $display("FAIL csum_disabled: got %h, want 0000", csum);
        end
`endif
        do_read(12'h700, 258, 2);
    endtask

    initial begin
        for (int i = 0; i < MSIZE; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        for (int k = 0; k < RL; k++) rpipe[k] = 8'h00;
        clear_mon();
        test_reset();
        test_fill_read_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_start_while_busy();
        test_reset_mid_read();
        test_random();
        test_csum();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
